// File: rtl/ibar_handler.sv
// -----------------------------------------------------------------------------
// ibar_handler
//
// Purpose
//   Consumes the IBAR pulse raised by the fetch-queue pre-decoder. On an IBAR,
//   the block does the following in order:
//     1. Freezes and flushes the front end.
//     2. Waits for the back end and the store buffer to drain.
//     3. Optionally invalidates the whole I-cache.
//     4. Redirects fetch to the instruction after the IBAR.
//   It sits between the FIFO pre-decoder and the IF0 PC-select / I-cache
//   control.
//
// Build option
//   IBAR_ICACHE_INV_EN : when defined, an I-cache invalidate-all handshake is
//                        inserted between the drain and the redirect. When it
//                        is undefined:
//                          - o_ic_inv_req is tied to 0.
//                          - i_ic_inv_ready and i_ic_inv_done are ignored.
//                        The port list is the same in both builds.
//
// Parameters
//   PC_W   width of the PC and of the redirect address
//   CNT_W  width of the completed-IBAR counter
//
// Ports
//   clk               in   clock
//   rstn              in   asynchronous active-low reset
//   i_ibar_signal     in   1-cycle pulse: an IBAR is present in the current
//                          FIFO pair
//   i_pc_from_ibar    in   PC of inst0 of the pair that holds the IBAR
//   i_ibar_pos        in   0: inst0 is the IBAR, 1: inst1 is the IBAR
//   i_pipe_empty      in   the back end holds no in-flight instruction
//   i_sb_empty        in   the store buffer / D-cache writeback is drained
//   i_ic_inv_ready    in   the I-cache accepts the invalidate-all request
//   i_ic_inv_done     in   1-cycle pulse: the invalidate-all is complete
//   o_fe_stall        out  hold IF0/IF1/FIFO (high in every state except idle)
//   o_fe_flush        out  1-cycle pulse: clear the IF stages and the fetch FIFO
//   o_ic_inv_req      out  invalidate-all request (valid of a valid/ready pair)
//   o_redirect_valid  out  1-cycle pulse: load o_redirect_pc into the fetch PC
//   o_redirect_pc     out  address of the instruction after the IBAR
//   o_busy            out  the handler is not idle (always equal to o_fe_stall)
//   o_ibar_cnt        out  number of completed IBARs (wraps)
//
// All outputs come straight from flops, so no combinational path runs from
// any input to any output.
// -----------------------------------------------------------------------------
module ibar_handler #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_ibar_signal,
   input  logic [PC_W-1:0]  i_pc_from_ibar,
   input  logic             i_ibar_pos,
   input  logic             i_pipe_empty,
   input  logic             i_sb_empty,
   input  logic             i_ic_inv_ready,
   input  logic             i_ic_inv_done,
   output logic             o_fe_stall,
   output logic             o_fe_flush,
   output logic             o_ic_inv_req,
   output logic             o_redirect_valid,
   output logic [PC_W-1:0]  o_redirect_pc,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_ibar_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_DRAIN,
      ST_INV_REQ,
      ST_INV_WAIT,
      ST_REDIRECT
   } state_t;

   state_t            r_state;
   state_t            w_next_state;

   logic              r_fe_stall;
   logic              r_fe_flush;
   logic              r_redirect_valid;
   logic [PC_W-1:0]   r_redirect_pc;
   logic [CNT_W-1:0]  r_ibar_cnt;

   logic              w_fe_stall_nxt;
   logic              w_fe_flush_nxt;
   logic              w_redirect_valid_nxt;
   logic              w_drained;
   logic              w_accept;
   logic [PC_W-1:0]   w_pc_offset;

`ifdef IBAR_ICACHE_INV_EN
   logic              r_ic_inv_req;
   logic              r_inv_done_seen;
   logic              w_ic_inv_req_nxt;
   logic              w_handshake;
`else
   logic              w_unused_inv;
`endif

   // The back end is quiescent only when both drain conditions hold in the
   // same cycle.
   assign w_drained = i_pipe_empty && i_sb_empty;

   // An IBAR pulse is honoured only in idle. While busy, the front end is
   // stalled or flushed, so a pulse seen then cannot belong to a live
   // instruction and is dropped.
   assign w_accept  = (r_state == ST_IDLE) && i_ibar_signal;

   // The redirect target is the instruction after the IBAR: one slot past
   // inst0 or two slots past it. The sum wraps modulo 2^PC_W.
   assign w_pc_offset = i_ibar_pos ? PC_W'(8) : PC_W'(4);

`ifdef IBAR_ICACHE_INV_EN
   assign w_handshake = (r_state == ST_INV_REQ) && i_ic_inv_ready;
`else
   // The invalidate handshake inputs have no function in this build.
   assign w_unused_inv = i_ic_inv_ready ^ i_ic_inv_done;
`endif

   // ---------------------------------------------------------------------------
   // Next-state logic and next-output decode.
   // The outputs are a pure function of the state being entered, and they are
   // registered together with the state. They therefore line up with the
   // state itself and carry no input-to-output combinational path.
   // ---------------------------------------------------------------------------
   // NOTE: every signal written here gets a default at the top of the block, so
   // no path can leave it unassigned and infer a latch.
   always_comb begin
      w_next_state         = r_state;
      w_fe_stall_nxt       = 1'b0;
      w_fe_flush_nxt       = 1'b0;
      w_redirect_valid_nxt = 1'b0;
`ifdef IBAR_ICACHE_INV_EN
      w_ic_inv_req_nxt     = 1'b0;
`endif

      case (r_state)
         ST_IDLE: begin
            if (i_ibar_signal) begin
               w_next_state = ST_FLUSH;
            end
         end

         ST_FLUSH: begin
            w_next_state = ST_DRAIN;
         end

         ST_DRAIN: begin
            if (w_drained) begin
`ifdef IBAR_ICACHE_INV_EN
               w_next_state = ST_INV_REQ;
`else
               w_next_state = ST_REDIRECT;
`endif
            end
         end

`ifdef IBAR_ICACHE_INV_EN
         ST_INV_REQ: begin
            // The request stays up until the I-cache takes it.
            if (i_ic_inv_ready) begin
               w_next_state = ST_INV_WAIT;
            end
         end

         ST_INV_WAIT: begin
            // The done pulse may already have arrived in the handshake cycle.
            // The sticky flag covers that case, and this state then lasts
            // one cycle.
            if (i_ic_inv_done || r_inv_done_seen) begin
               w_next_state = ST_REDIRECT;
            end
         end
`else
         ST_INV_REQ,
         ST_INV_WAIT: begin
            w_next_state = ST_IDLE;
         end
`endif

         ST_REDIRECT: begin
            w_next_state = ST_IDLE;
         end

         default: begin
            w_next_state = ST_IDLE;
         end
      endcase

      w_fe_stall_nxt       = (w_next_state != ST_IDLE);
      w_fe_flush_nxt       = (w_next_state == ST_FLUSH);
      w_redirect_valid_nxt = (w_next_state == ST_REDIRECT);
`ifdef IBAR_ICACHE_INV_EN
      w_ic_inv_req_nxt     = (w_next_state == ST_INV_REQ);
`endif
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   // NOTE: state uses non-blocking assignments, so every flop samples values
   // from before the clock edge and the order of statements does not matter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state          <= ST_IDLE;
         r_fe_stall       <= 1'b0;
         r_fe_flush       <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_ibar_cnt       <= '0;
      end else begin
         r_state          <= w_next_state;
         r_fe_stall       <= w_fe_stall_nxt;
         r_fe_flush       <= w_fe_flush_nxt;
         r_redirect_valid <= w_redirect_valid_nxt;

         if (w_accept) begin
            r_redirect_pc <= i_pc_from_ibar + w_pc_offset;
         end

         // Count on entry to REDIRECT so the new value appears with the
         // redirect pulse.
         if (w_next_state == ST_REDIRECT) begin
            r_ibar_cnt <= r_ibar_cnt + CNT_W'(1);
         end
      end
   end

`ifdef IBAR_ICACHE_INV_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ic_inv_req    <= 1'b0;
         r_inv_done_seen <= 1'b0;
      end else begin
         r_ic_inv_req    <= w_ic_inv_req_nxt;
         // Set only by a done that coincides with the handshake. It is read
         // in the single INV_WAIT cycle that follows, then clears by itself.
         r_inv_done_seen <= w_handshake && i_ic_inv_done;
      end
   end

   assign o_ic_inv_req = r_ic_inv_req;
`else
   assign o_ic_inv_req = 1'b0;
`endif

   assign o_fe_stall       = r_fe_stall;
   assign o_busy           = r_fe_stall;
   assign o_fe_flush       = r_fe_flush;
   assign o_redirect_valid = r_redirect_valid;
   assign o_redirect_pc    = r_redirect_pc;
   assign o_ibar_cnt       = r_ibar_cnt;

   // ---------------------------------------------------------------------------
   // Protocol properties
   // ---------------------------------------------------------------------------
   a_flush_single_cycle : assert property (
      @(posedge clk) disable iff (!rstn) o_fe_flush |=> !o_fe_flush);

   a_redirect_single_cycle : assert property (
      @(posedge clk) disable iff (!rstn) o_redirect_valid |=> !o_redirect_valid);

`ifdef IBAR_ICACHE_INV_EN
   a_inv_req_held : assert property (
      @(posedge clk) disable iff (!rstn) (o_ic_inv_req && !i_ic_inv_ready) |=> o_ic_inv_req);
`endif

endmodule
